output_stream_buffer: RTL and testbench

- Parametrised successor to the fixed 16x32 output buffer.
- Collects per-cycle results from the systolic array into a DEPTH-entry store with per-entry valid bits.
- Returns data to the external interface in two ways: a single random read, or a burst drain of a contiguous, wrapping address range.
- All output leaves through one valid/ready-handshaked register stage.

---
 rtl/outbuf_pkg.sv | 26 ++
 rtl/output_stream_buffer_if.sv | 39 +++
 rtl/outbuf_out_stage.sv | 52 +++++
 rtl/output_stream_buffer.sv | 163 ++++++++++++++++
 tb/tb_output_stream_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outbuf_pkg.sv
// -----------------------------------------------------------------------------
// outbuf_pkg
// Shared types and defaults for the output stream buffer.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   state_e                : drain controller states
//   beat_flags_t           : per-beat sideband (last, miss) for the output stage
// -----------------------------------------------------------------------------
package outbuf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // An out-beat is {data, last, miss}. The data word width is a module
    // parameter that a package cannot follow, so the package carries the
    // fixed-width part and the data word travels beside it.
    typedef struct packed {
        logic last;
        logic miss;
    } beat_flags_t;

endpackage : outbuf_pkg

// File: rtl/output_stream_buffer_if.sv
// -----------------------------------------------------------------------------
// output_stream_buffer_if
// Valid/ready output stream of the output stream buffer.
//   out_data  : output word
//   out_valid : out_data valid
//   out_ready : consumer accepts the beat
//   out_last  : final beat of a drain
//   out_miss  : beat came from an invalid entry
// Modports: master (buffer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface output_stream_buffer_if
    import outbuf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              out_miss;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_miss,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_miss,
        output out_ready
    );

endinterface : output_stream_buffer_if

// File: rtl/outbuf_out_stage.sv
// -----------------------------------------------------------------------------
// outbuf_out_stage
// Single valid/ready output register. The producer loads a beat with i_load
// only while o_free is high; a held beat stays stable until out_ready.
//   clk, rst  : clock, asynchronous active-low reset
//   i_load    : load i_data/i_flags into the output register this edge
//   i_data    : word to present
//   i_flags   : last/miss sideband for the word
//   o_free    : register empty or being emptied this cycle
//   out_if    : output stream (master side)
// -----------------------------------------------------------------------------
module outbuf_out_stage
    import outbuf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [DATA_W-1:0]       i_data,
    input  beat_flags_t             i_flags,
    output logic                    o_free,
    output_stream_buffer_if.master  out_if
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    beat_flags_t       r_flags;

    assign o_free = !r_valid || out_if.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_flags <= '0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_flags <= i_flags;
            r_valid <= 1'b1;
        end else if (out_if.out_ready) begin
            // Data and flags hold their last value; only valid drops.
            r_valid <= 1'b0;
        end
    end

    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;
    assign out_if.out_last  = r_flags.last;
    assign out_if.out_miss  = r_flags.miss;

endmodule : outbuf_out_stage

// File: rtl/output_stream_buffer.sv
// -----------------------------------------------------------------------------
// output_stream_buffer
// DEPTH-entry result store with per-entry valid bits. Data leaves through one
// valid/ready register either as a single random read or as a burst drain of
// a contiguous address range that wraps modulo DEPTH.
//   clk, rst          : clock, asynchronous active-low reset
//   wr_en/addr/data   : store a word (allowed in any state)
//   wr_acc            : (OUTBUF_ACCUM_EN only) add into a valid entry
//   clear             : invalidate all entries (ignored while busy)
//   rd_en/rd_addr     : random-read request, rd_accept says it was taken
//   drain_start/base/len : start a burst drain of len beats (1..DEPTH)
//   busy              : drain in progress
//   out_if            : output stream (master side)
// Optional feature macro: OUTBUF_ACCUM_EN (accumulating writes).
// -----------------------------------------------------------------------------
module output_stream_buffer
    import outbuf_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
`ifdef OUTBUF_ACCUM_EN
    input  logic                    wr_acc,
`endif
    input  logic                    clear,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_accept,
    input  logic                    drain_start,
    input  logic [ADDR_W-1:0]       drain_base,
    input  logic [ADDR_W:0]         drain_len,
    output logic                    busy,
    output_stream_buffer_if.master  out_if
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W:0]   r_rem, w_rem_nxt;

    logic              w_free;
    logic              w_load;
    logic              w_last;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_wr_word;
    logic [DATA_W-1:0] w_beat_data;
    beat_flags_t       w_flags;

    assign busy = (r_state == DRAIN);

    // ---------------------------------------------------------------- storage
`ifdef OUTBUF_ACCUM_EN
    // Accumulate only into a valid entry; otherwise it is a plain write.
    assign w_wr_word = (wr_acc && r_valid[wr_addr]) ? r_mem[wr_addr] + wr_data
                                                    : wr_data;
`else
    assign w_wr_word = wr_data;
`endif

    // NOTE: the data array has no reset; r_valid alone says what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (clear && !busy) begin
                r_valid <= '0;
            end
            // NOTE: the later non-blocking assignment wins, so a same-cycle
            // write keeps its entry valid through a clear.
            if (wr_en) begin
                r_valid[wr_addr] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------- drain controller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_rem;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_rd_addr   = rd_addr;
        rd_accept   = 1'b0;

        case (r_state)
            IDLE: begin
                // drain_start (even with len 0) blocks a same-cycle read.
                if (drain_start) begin
                    if (drain_len != '0) begin
                        w_state_nxt = DRAIN;
                        w_ptr_nxt   = drain_base;
                        w_rem_nxt   = drain_len;
                    end
                end else if (rd_en && w_free) begin
                    rd_accept = 1'b1;
                    w_load    = 1'b1;
                end
            end
            DRAIN: begin
                w_rd_addr = r_ptr;
                if (w_free) begin
                    w_load    = 1'b1;
                    w_last    = (r_rem == REM_ONE);
                    w_ptr_nxt = r_ptr + PTR_ONE;   // wraps since DEPTH is 2^n
                    w_rem_nxt = r_rem - REM_ONE;
                    if (r_rem == REM_ONE) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reads see pre-write contents, giving old-data on a same-cycle collision.
    assign w_beat_data = r_valid[w_rd_addr] ? r_mem[w_rd_addr] : '0;
    assign w_flags     = '{last: w_last, miss: !r_valid[w_rd_addr]};

    // ------------------------------------------------------------ output stage
    outbuf_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_beat_data),
        .i_flags (w_flags),
        .o_free  (w_free),
        .out_if  (out_if)
    );

endmodule : output_stream_buffer

// File: tb/tb_output_stream_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_stream_buffer
// Self-checking bench for output_stream_buffer (DATA_W=32, DEPTH=16).
// A cycle-level reference model (plain arrays and counters) predicts every
// output; directed scenarios add fixed expected constants, then a random phase
// runs against the model. Honours OUTBUF_ACCUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_output_stream_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef OUTBUF_ACCUM_EN
    logic              wr_acc;
`else
    localparam logic   wr_acc = 1'b0;
`endif
    logic              clear;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_accept;
    logic              drain_start;
    logic [ADDR_W-1:0] drain_base;
    logic [ADDR_W:0]   drain_len;
    logic              busy;

    output_stream_buffer_if #(.DATA_W(DATA_W)) bus ();

    output_stream_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef OUTBUF_ACCUM_EN
        .wr_acc      (wr_acc),
`endif
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_accept   (rd_accept),
        .drain_start (drain_start),
        .drain_base  (drain_base),
        .drain_len   (drain_len),
        .busy        (busy),
        .out_if      (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ bookkeeping
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------- reference model
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_val [DEPTH];
    bit                m_busy;
    int                m_next;      // next drain address
    int                m_left;      // drain beats still to load
    bit                m_ov, m_ol, m_om;
    logic [DATA_W-1:0] m_od;
    logic [DATA_W-1:0] got_q [$];   // beats handed over (valid && ready)

    task automatic m_reset();
        m_busy = 1'b0;
        m_next = 0;
        m_left = 0;
        m_ov   = 1'b0;
        m_ol   = 1'b0;
        m_om   = 1'b0;
        m_od   = '0;
        for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    endtask

    function automatic bit m_accept();
        return rd_en && !m_busy && !drain_start && (!m_ov || bus.out_ready);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic m_edge();
        bit free;
        bit was_busy;
        bit load;
        bit last;
        int a;
        free     = !m_ov || bus.out_ready;
        was_busy = m_busy;
        load     = 1'b0;
        last     = 1'b0;
        a        = 0;
        if (m_accept()) begin
            load = 1'b1;
            a    = int'(rd_addr);
        end else if (m_busy && free) begin
            load   = 1'b1;
            a      = m_next;
            last   = (m_left == 1);
            m_next = (m_next + 1) % DEPTH;
            m_left = m_left - 1;
            if (m_left == 0) m_busy = 1'b0;
        end
        if (load) begin
            m_ov = 1'b1;
            m_od = m_val[a] ? m_mem[a] : '0;
            m_om = !m_val[a];
            m_ol = last;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        if (!was_busy && drain_start && drain_len != 0) begin
            m_busy = 1'b1;
            m_next = int'(drain_base);
            m_left = int'(drain_len);
        end
        if (clear && !was_busy) begin
            for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
        end
        if (wr_en) begin
            if (wr_acc && m_val[wr_addr]) m_mem[wr_addr] = m_mem[wr_addr] + wr_data;
            else                          m_mem[wr_addr] = wr_data;
            m_val[wr_addr] = 1'b1;
        end
    endtask

    // ------------------------------------------------------------ drive helpers
    task automatic idle();
        wr_en          = 1'b0;
        clear          = 1'b0;
        rd_en          = 1'b0;
        drain_start    = 1'b0;
        bus.out_ready  = 1'b1;
`ifdef OUTBUF_ACCUM_EN
        wr_acc         = 1'b0;
`endif
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge after checking all outputs against the model.
    task automatic tick();
        #1;
        check("rd_accept", rd_accept, m_accept());
        if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        m_edge();
        @(negedge clk);
        check("out_valid", bus.out_valid, m_ov);
        check("busy", busy, m_busy);
        if (m_ov) begin
            check("out_data", bus.out_data, m_od);
            check("out_last", bus.out_last, m_ol);
            check("out_miss", bus.out_miss, m_om);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [DATA_W-1:0] exp_wrap [4];
    logic [DATA_W-1:0] prev;
    bit                ready_pat [5];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        idle();
        wr_addr    = '0;
        wr_data    = '0;
        rd_addr    = '0;
        drain_base = '0;
        drain_len  = '0;
        rst        = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_miss", bus.out_miss, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Write then random read: one cycle latency
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 4'd3;
        #1 check("t1_accept", rd_accept, 1'b1);
        tick();
        idle();
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_data", bus.out_data, 32'hDEADBEEF);
        check("t1_miss", bus.out_miss, 1'b0);
        check("t1_last", bus.out_last, 1'b0);

        // Never-written entry, then clear
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        idle();
        check("t2_unwritten_data", bus.out_data, 32'h0);
        check("t2_unwritten_miss", bus.out_miss, 1'b1);
        clear = 1'b1;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        idle();
        check("t2_cleared_data", bus.out_data, 32'h0);
        check("t2_cleared_miss", bus.out_miss, 1'b1);

        // Wrapping drain at full throughput
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 32'(a * 32'h11);
            tick();
        end
        idle();
        drain_start = 1'b1; drain_base = 4'd14; drain_len = 5'd4;
        tick();
        idle();
        check("t3_busy_start", busy, 1'b1);
        exp_wrap = '{32'hEE, 32'hFF, 32'h00, 32'h11};
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_beat_valid", bus.out_valid, 1'b1);
            check("t3_beat_data", bus.out_data, exp_wrap[k]);
            check("t3_beat_last", bus.out_last, k == 3);
            check("t3_beat_busy", busy, k != 3);
        end
        tick();
        check("t3_drained", bus.out_valid, 1'b0);

        // Drain with back-pressure; reads refused while busy
        got_q.delete();
        drain_start = 1'b1; drain_base = 4'd0; drain_len = 5'd3;
        tick();
        idle();
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int j = 0; j < 5; j++) begin
            bus.out_ready = ready_pat[j];
            rd_en         = !ready_pat[j];
            rd_addr       = 4'd5;
            prev          = bus.out_data;
            if (!ready_pat[j]) begin
                #1 check("t4_rd_during_busy", rd_accept, 1'b0);
            end
            tick();
            if (!ready_pat[j]) check("t4_stall_hold", bus.out_data, prev);
        end
        idle();
        for (int i = 0; i < 10 && got_q.size() < 3; i++) tick();
        tick();
        check("t4_beat_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t4_beat0", got_q[0], 32'h00);
            check("t4_beat1", got_q[1], 32'h11);
            check("t4_beat2", got_q[2], 32'h22);
        end

        // Same-cycle read/write collision; zero-length drain
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h9;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h5;
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        idle();
        check("t5_collide_old", bus.out_data, 32'h9);
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        idle();
        check("t5_after_write", bus.out_data, 32'h5);
        drain_start = 1'b1; drain_len = 5'd0; rd_en = 1'b1;
        #1 check("t5_drain_blocks_rd", rd_accept, 1'b0);
        tick();
        idle();
        check("t5_len0_busy", busy, 1'b0);

`ifdef OUTBUF_ACCUM_EN
        // Accumulate wraps modulo 2^32; same-cycle read sees pre-add value
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFFFFFFFF;
        tick();
        wr_acc = 1'b1; wr_data = 32'h2;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 4'd1;
        tick();
        idle();
        check("t6_acc_wrap", bus.out_data, 32'h1);
        wr_en = 1'b1; wr_acc = 1'b1; wr_addr = 4'd1; wr_data = 32'h5;
        rd_en = 1'b1; rd_addr = 4'd1;
        tick();
        idle();
        check("t6_acc_pre_add", bus.out_data, 32'h1);
        rd_en = 1'b1; rd_addr = 4'd1;
        tick();
        idle();
        check("t6_acc_post_add", bus.out_data, 32'h6);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wr_en         = 1'($urandom_range(0, 1));
            wr_addr       = 4'($urandom);
            wr_data       = $urandom;
            clear         = ($urandom_range(0, 49) == 0);
            rd_en         = ($urandom_range(0, 2) != 0);
            rd_addr       = 4'($urandom);
            drain_start   = ($urandom_range(0, 15) == 0);
            drain_base    = 4'($urandom);
            drain_len     = 5'($urandom_range(0, DEPTH));
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef OUTBUF_ACCUM_EN
            wr_acc        = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        idle();

        // Asynchronous reset in the middle of a drain
        drain_start = 1'b1; drain_base = 4'd0; drain_len = 5'd8;
        tick();
        idle();
        tick();
        tick();
        check("t7_pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t7_rst_valid", bus.out_valid, 1'b0);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_data", bus.out_data, 32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        idle();
        check("t7_post_rst_miss", bus.out_miss, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_output_stream_buffer
